// File: rtl/iomem_pkg.sv
// -----------------------------------------------------------------------------
// iomem_pkg
// Shared definitions for the iomem initiator: FSM state encoding, response
// error codes, wait-counter width and the default bus timeout.
// -----------------------------------------------------------------------------
package iomem_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  // rsp_err codes
  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_MISALIGN = 2'd2;

  // Wait counter width and default bus timeout (in bus cycles)
  localparam int          CNT_W                  = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/iomem_initiator.sv
// -----------------------------------------------------------------------------
// iomem_initiator
// Turns single commands (address, write data, byte strobes) into one iomem
// bus transaction and returns a response with read data and an error code.
// One command is outstanding at a time; misaligned addresses are rejected
// without a bus cycle and an unresponsive bus is abandoned after
// TIMEOUT_CYCLES cycles.
//
// Handshakes: every channel uses valid/ready. A transfer happens on a rising
// clk edge where both valid and ready are high; valid, once raised, is held
// with its payload stable until that transfer. The iomem side is the
// exception: iomem_ready is a single-cycle acknowledge from the responder.
//
// Ports
//   clk, resetn             clock, synchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only in IDLE)
//   cmd_addr/wdata/wstrb    command payload; wstrb == 0 means read
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata/rsp_err       response payload (rdata 0 for writes/errors)
//   iomem_valid/ready       bus request / single-cycle acknowledge
//   iomem_addr/wdata/wstrb  bus request payload
//   iomem_rdata             bus read data, valid with iomem_ready
//   busy                    high whenever the FSM is not in IDLE
//   dbg_state               current FSM state
// -----------------------------------------------------------------------------
module iomem_initiator
  import iomem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  output logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_rdata,
  output logic        busy,
  output state_e      dbg_state
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  state_e             state_q, state_d;
  logic [31:0]        addr_q,  addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [1:0]         err_q,   err_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [CNT_W-1:0]   cnt_inc;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_addr[1:0] != 2'b00) begin
            // Rejected before any bus activity
            err_d   = ERR_MISALIGN;
            rdata_d = '0;
            state_d = ST_RSP;
          end else begin
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
            wstrb_d = cmd_wstrb;
            cnt_d   = '0;
            state_d = ST_BUS;
          end
        end
      end

      ST_BUS: begin
        // Acknowledge is checked first so it wins over a coincident timeout
        if (iomem_ready) begin
          rdata_d = (wstrb_q == 4'b0000) ? iomem_rdata : 32'd0;
          err_d   = ERR_OK;
          state_d = ST_RSP;
        end else begin
          cnt_d = cnt_inc;
          // cnt_q counts earlier unacknowledged cycles, so this cycle is
          // the TIMEOUT_CYCLES-th one with iomem_valid high.
          if (cnt_inc == TIMEOUT_LIM) begin
            rdata_d = '0;
            err_d   = ERR_TIMEOUT;
            state_d = ST_RSP;
          end
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs decode straight from state, so iomem_valid drops in
  // the cycle after the acknowledge or timeout and right after reset.
  assign cmd_ready   = (state_q == ST_IDLE);
  assign iomem_valid = (state_q == ST_BUS);
  assign rsp_valid   = (state_q == ST_RSP);
  assign busy        = (state_q != ST_IDLE);
  assign iomem_addr  = addr_q;
  assign iomem_wdata = wdata_q;
  assign iomem_wstrb = wstrb_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_iomem_initiator.sv
// -----------------------------------------------------------------------------
// tb_iomem_initiator
// Directed bench for iomem_initiator (TIMEOUT_CYCLES = 4) with a small
// memory-backed responder whose acknowledge delay is programmable.
// -----------------------------------------------------------------------------
module tb_iomem_initiator;
  import iomem_pkg::*;

  localparam int unsigned TO = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        iomem_valid;
  logic        iomem_ready = 1'b0;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_rdata = '0;
  logic        busy;
  state_e      dbg_state;

  iomem_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wstrb   (cmd_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_wstrb (iomem_wstrb),
    .iomem_rdata (iomem_rdata),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- responder ----------------
  bit          resp_en = 1'b1;
  int          resp_delay = 0;
  bit          force_ready = 1'b0;
  int          resp_cnt = 0;
  logic [31:0] mem [0:15];
  logic [3:0]  idx;

  always @(negedge clk) begin
    if (!resetn) begin
      iomem_ready = 1'b0;
      resp_cnt    = 0;
    end else if (resp_en && iomem_valid && !iomem_ready) begin
      if (resp_cnt >= resp_delay) begin
        iomem_ready = 1'b1;
        resp_cnt    = 0;
        idx         = iomem_addr[5:2];
        if (iomem_wstrb == 4'b0000) begin
          iomem_rdata = mem[idx];
        end else begin
          for (int b = 0; b < 4; b++)
            if (iomem_wstrb[b]) mem[idx][8*b +: 8] = iomem_wdata[8*b +: 8];
          iomem_rdata = 32'hDEAD_BEEF;
        end
      end else begin
        iomem_ready = 1'b0;
        resp_cnt++;
      end
    end else begin
      iomem_ready = force_ready;
      resp_cnt    = 0;
    end
  end

  // ---------------- bus monitor ----------------
  logic        prev_v = 1'b0;
  int          bursts = 0;
  int          vcycles = 0;
  int          unstable = 0;
  logic [31:0] b_addr, b_wdata;
  logic [3:0]  b_wstrb;

  always @(negedge clk) begin
    if (iomem_valid) begin
      vcycles++;
      if (!prev_v) begin
        bursts++;
        b_addr  = iomem_addr;
        b_wdata = iomem_wdata;
        b_wstrb = iomem_wstrb;
      end else if (iomem_addr !== b_addr || iomem_wdata !== b_wdata ||
                   iomem_wstrb !== b_wstrb) begin
        unstable++;
      end
    end
    prev_v = iomem_valid;
  end

  // ---------------- scoreboard helper ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [31:0] a, input logic [31:0] w,
                          input logic [3:0] s, output int acc_cyc);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_wdata = w;
    cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept_bound", 32'(cmd_ready), 32'd1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = 32'hFFFF_FFFF;
    cmd_wstrb = 4'hF;
  endtask

  task automatic wait_rsp(output int rsp_cyc);
    int n;
    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rsp_wait_bound", 32'(rsp_valid), 32'd1);
    rsp_cyc = cyc;
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  int          acc, rc, b0, v0;
  logic [31:0] rd;
  logic [1:0]  er;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem[1] = 32'hA5A5_0001;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready",   32'(cmd_ready),   32'd1);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_iomem_valid", 32'(iomem_valid), 32'd0);
    check("rst_rsp_valid",   32'(rsp_valid),   32'd0);
    check("rst_rsp_err",     32'(rsp_err),     32'd0);
    check("rst_rsp_rdata",   rsp_rdata,        32'd0);
    check("rst_iomem_addr",  iomem_addr,       32'd0);
    check("rst_iomem_wstrb", 32'(iomem_wstrb), 32'd0);
    check("rst_state",       32'(dbg_state),   32'(ST_IDLE));
    resetn = 1'b1;

    // Write, responder acknowledges after 2 wait cycles
    resp_en = 1'b1; resp_delay = 2;
    b0 = bursts; v0 = vcycles;
    send_cmd(32'h0400_0000, 32'h1234_5678, 4'hF, acc);
    wait_rsp(rc);
    check("wr_err",      32'(rsp_err), 32'(ERR_OK));
    check("wr_rdata",    rsp_rdata,    32'd0);
    ack_rsp();
    check("wr_bursts",   32'(bursts - b0),  32'd1);
    check("wr_vcycles",  32'(vcycles - v0), 32'd3);
    check("wr_bus_addr", b_addr,  32'h0400_0000);
    check("wr_bus_data", b_wdata, 32'h1234_5678);
    check("wr_stable",   32'(unstable), 32'd0);

    // Read back the same address, zero-wait
    resp_delay = 0;
    send_cmd(32'h0400_0000, 32'h0, 4'h0, acc);
    wait_rsp(rc);
    check("rdback_rdata", rsp_rdata,    32'h1234_5678);
    check("rdback_err",   32'(rsp_err), 32'(ERR_OK));
    ack_rsp();

    // Zero-wait read: data and accept-to-response latency
    send_cmd(32'h0400_0004, 32'h0, 4'h0, acc);
    wait_rsp(rc);
    check("rd_rdata",   rsp_rdata, 32'hA5A5_0001);
    check("rd_latency", 32'(rc - acc + 1), 32'd3);
    ack_rsp();

    // Timeout: responder silent
    resp_en = 1'b0;
    b0 = bursts; v0 = vcycles;
    send_cmd(32'h0400_0008, 32'h0, 4'h0, acc);
    wait_rsp(rc);
    check("to_err",     32'(rsp_err), 32'(ERR_TIMEOUT));
    check("to_rdata",   rsp_rdata,    32'd0);
    check("to_vcycles", 32'(vcycles - v0), 32'(TO));
    check("to_bursts",  32'(bursts - b0),  32'd1);
    // Late acknowledge while the response waits
    force_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("late_rsp_valid", 32'(rsp_valid), 32'd1);
    check("late_rsp_err",   32'(rsp_err),   32'(ERR_TIMEOUT));
    check("late_no_bus",    32'(vcycles - v0), 32'(TO));
    ack_rsp();
    @(negedge clk);
    check("late_idle_valid", 32'(iomem_valid), 32'd0);
    check("late_idle_busy",  32'(busy),        32'd0);
    check("late_idle_ready", 32'(cmd_ready),   32'd1);
    force_ready = 1'b0;
    resp_en = 1'b1;

    // Misaligned address: no bus cycle
    b0 = bursts;
    send_cmd(32'h0300_0002, 32'hCAFE_F00D, 4'hF, acc);
    wait_rsp(rc);
    check("mis_err",     32'(rsp_err), 32'(ERR_MISALIGN));
    check("mis_rdata",   rsp_rdata,    32'd0);
    check("mis_latency", 32'(rc - acc + 1), 32'd2);
    ack_rsp();
    check("mis_bursts",  32'(bursts - b0), 32'd0);

    // Response held with rsp_ready low for 10 cycles
    resp_delay = 0;
    send_cmd(32'h0400_0004, 32'h0, 4'h0, acc);
    wait_rsp(rc);
    for (int k = 0; k < 10; k++) begin
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata,      32'hA5A5_0001);
      check("hold_err",   32'(rsp_err),   32'(ERR_OK));
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    ack_rsp();

    // Acknowledge coinciding with timeout: ready wins
    resp_delay = int'(TO) - 1;
    v0 = vcycles;
    send_cmd(32'h0400_0004, 32'h0, 4'h0, acc);
    wait_rsp(rc);
    check("coin_err",     32'(rsp_err), 32'(ERR_OK));
    check("coin_rdata",   rsp_rdata,    32'hA5A5_0001);
    check("coin_vcycles", 32'(vcycles - v0), 32'(TO));
    ack_rsp();

    // Reset pulsed during BUS
    resp_en = 1'b0;
    send_cmd(32'h0400_000C, 32'h5555_AAAA, 4'hF, acc);
    @(negedge clk);
    check("rst_mid_bus", 32'(iomem_valid), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_abort_valid", 32'(iomem_valid), 32'd0);
    check("rst_abort_rsp",   32'(rsp_valid),   32'd0);
    check("rst_abort_busy",  32'(busy),        32'd0);
    check("rst_abort_addr",  iomem_addr,       32'd0);
    check("rst_abort_rdata", rsp_rdata,        32'd0);
    resetn = 1'b1;
    resp_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Normal traffic resumes
    send_cmd(32'h0400_0000, 32'h0, 4'h0, acc);
    wait_rsp(rc);
    check("resume_rdata", rsp_rdata, 32'h1234_5678);
    ack_rsp();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
